display_scan_mux: RTL
=====================

DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 SHALL have parameter PRESCALE, default 1000: clk cycles per digit slot, minimum 2.
REQ-003 SHALL have parameter BLANK_CYCLES, default 2: blanked cycles at the start of each slot, below PRESCALE.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port seg_data, input, 8*NUM_DIGITS bits: digit k occupies [8k+7:8k], bit order {P,G,F,E,D,C,B,A}, 1 = segment lit.
REQ-007 SHALL have port digit_en, input, NUM_DIGITS bits: 1 = digit k shown, 0 = digit k dark.
REQ-008 SHALL have port scan_en, input, 1 bit: 1 = scanning runs, 0 = scanning paused and display dark.
REQ-009 SHALL have port seg_n, output, 8 bits: segment drive, active-low, same bit order as seg_data.
REQ-010 SHALL have port dig_n, output, NUM_DIGITS bits: digit select, active-low, at most one bit low.
REQ-011 SHALL have port frame_start, output, 1 bit: one-cycle pulse at each frame boundary.
REQ-012 SHALL have port cur_digit, output, max(1,clog2(NUM_DIGITS)) bits: current slot index.

Function
REQ-013 SHALL keep a prescaler counting 0..PRESCALE-1 while scan_en=1; at PRESCALE-1 it wraps to 0 and the slot index advances.
REQ-014 SHALL wrap the slot index from NUM_DIGITS-1 to 0.
REQ-015 SHALL load seg_data and digit_en into shadow registers on the edge where state goes from (index NUM_DIGITS-1, prescaler PRESCALE-1) to (0,0); outputs use only the shadow values, so a frame is never torn.
REQ-016 SHALL assert frame_start for exactly the cycle following that shadow-load edge, and at no other time.
REQ-017 SHALL register seg_n and dig_n so they reflect the index, prescaler and shadow state valid in the same cycle, with no extra latency and no combinational glitches.
REQ-018 SHALL drive dig_n[k] low only when index==k, scan_en=1, shadow digit_en[k]=1 and not blanking; seg_n SHALL then equal ~shadow seg_data of digit k.
REQ-019 SHALL otherwise drive dig_n all ones and seg_n 8'hFF.
REQ-020 SHALL let a disabled digit keep its full slot time, so the refresh rate stays constant at NUM_DIGITS*PRESCALE cycles per frame.
REQ-021 SHALL, while scan_en=0, hold the prescaler, index and shadow, force frame_start to 0, and resume from the held state when scan_en returns to 1.
REQ-022 SHALL drive cur_digit equal to the slot index at all times, including while paused.

Reset
REQ-023 SHALL, when rst=1 at a rising edge, set prescaler 0, index 0, shadow 0, seg_n 8'hFF, dig_n all ones, frame_start 0 and cur_digit 0.
REQ-024 SHALL give rst priority over scan_en and apply it identically mid-slot or mid-frame.
REQ-025 SHALL display all digits dark for the first frame after reset, because the shadow is 0 until the first frame boundary.

Configuration
REQ-026 SHALL, with DISPLAY_SCAN_BLANK_EN defined, treat prescaler values 0..BLANK_CYCLES-1 of every slot as blanking (anti-ghosting): dig_n all ones and seg_n 8'hFF.
REQ-027 SHALL, with DISPLAY_SCAN_BLANK_EN undefined, have no blanking; the selected digit is driven for all PRESCALE cycles and BLANK_CYCLES is ignored.

Verification
Bench parameters for all scenarios: NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=1, macro defined unless stated; cycle 0 = first cycle after rst is released.
REQ-028 SHALL cover first frame: rst pulse, then scan_en=1, seg_data=32'h3F065B4F, digit_en=4'hF -> cycles 0-15 dig_n=4'hF and seg_n=8'hFF; cycle 16 frame_start=1 and display blank; cycles 17-19 dig_n=4'b1110 and seg_n=8'hB0; cycles 21-23 dig_n=4'b1101 and seg_n=8'hA4.
REQ-029 SHALL cover snapshot: seg_data changed to 32'h0 at cycle 22 -> frame 16-31 still shows the old patterns; from cycle 33 seg_n=8'hFF with digits selected.
REQ-030 SHALL cover disabled digit: digit_en=4'b1011 -> throughout slot 2 dig_n=4'hF and seg_n=8'hFF; frame_start period stays 16 cycles.
REQ-031 SHALL cover pause: scan_en=0 for 10 cycles at index 2, prescaler 1 -> outputs dark, cur_digit=2 held; after resume, dig_n=4'b1011 for 2 cycles, then the slot advances.
REQ-032 SHALL cover mid-frame reset: rst at index 3 -> next cycle shows all reset values; next frame_start appears 16 cycles after rst is released.
REQ-033 SHALL cover macro off: DISPLAY_SCAN_BLANK_EN undefined -> dig_n=4'b1110 for all 4 cycles of slot 0, starting at cycle 16.

Source files
------------

// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexed seven-segment scan driver with frame-coherent shadow registers
//   params: NUM_DIGITS (2..8), PRESCALE (clk cycles per slot, >=2), BLANK_CYCLES (< PRESCALE)
//   ports : clk, rst (sync active-high), seg_data[8*NUM_DIGITS] {P,G..A} per digit, digit_en,
//           scan_en, seg_n (active-low), dig_n (active-low), frame_start pulse, cur_digit
//   macro : DISPLAY_SCAN_BLANK_EN blanks prescaler values 0..BLANK_CYCLES-1 of each slot
module display_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [8*NUM_DIGITS-1:0]       seg_data,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic                          scan_en,
  output logic [7:0]                    seg_n,
  output logic [NUM_DIGITS-1:0]         dig_n,
  output logic                          frame_start,
  output logic [$clog2(NUM_DIGITS)-1:0] cur_digit
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] B_END = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
`ifdef DISPLAY_SCAN_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif
  logic [PW-1:0] cnt, cnt_nx;
  logic [IW-1:0] idx_nx;
  logic [8*NUM_DIGITS-1:0] sh_seg, sh_seg_nx;
  logic [NUM_DIGITS-1:0] sh_en, sh_en_nx, dig_nx;
  logic [7:0] seg_nx;
  logic wrap, load, blank, lit;
  // Outputs are registered from next-state values so they line up with the
  // state of the same cycle without a pipeline delay.
  always_comb begin
    wrap = scan_en && cnt == P_LAST;
    load = wrap && cur_digit == I_LAST;
    cnt_nx = !scan_en ? cnt : wrap ? '0 : cnt + PW'(1);
    idx_nx = !wrap ? cur_digit : load ? '0 : cur_digit + IW'(1);
    sh_seg_nx = load ? seg_data : sh_seg;
    sh_en_nx = load ? digit_en : sh_en;
    blank = BLANK_EN && cnt_nx < B_END;
    lit = scan_en && sh_en_nx[idx_nx] && !blank;
    dig_nx = lit ? ~(NUM_DIGITS'(1) << idx_nx) : '1;
    seg_nx = lit ? ~sh_seg_nx[{idx_nx, 3'b000} +: 8] : 8'hFF;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      cur_digit <= '0;
      sh_seg <= '0;
      sh_en <= '0;
      seg_n <= 8'hFF;
      dig_n <= '1;
      frame_start <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      cur_digit <= idx_nx;
      sh_seg <= sh_seg_nx;
      sh_en <= sh_en_nx;
      seg_n <= seg_nx;
      dig_n <= dig_nx;
      frame_start <= load;
    end
  end
endmodule
